nco_sweep_ctrl: RTL and testbench
=================================

// Module: nco_sweep_ctrl
// PURPOSE
//  Frequency sweep/hop sequencer for the 4-lane phase accumulator.
//  Drives its p_inc_i and reset from a config set (start, stop, step, dwell, mode).
//  Steps the increment at programmed dwell intervals: linear chirp, repeating sawtooth or triangle sweep.
//  Sits between the control/register interface and the NCO.
// PARAMETERS
//  PINC_W   32  phase-increment width; must equal the accumulator input width
//  DWELL_W  16  dwell counter width; dwell = cycles spent on each increment value
// PORTS
//  clk_i        in   1        single clock, all logic on posedge
//  rst_i        in   1        asynchronous, active-high reset
//  cfg_valid_i  in   1        config word valid
//  cfg_ready_o  out  1        config accepted; high only in IDLE
//  cfg_start_i  in   PINC_W   first increment (unsigned)
//  cfg_stop_i   in   PINC_W   end increment (unsigned)
//  cfg_step_i   in   PINC_W   signed two's-complement increment delta
//  cfg_dwell_i  in   DWELL_W  cycles per value; 0 treated as 1
//  cfg_mode_i   in   2        0 SINGLE, 1 REPEAT (sawtooth), 2 TRIANGLE, 3 = SINGLE
//  start_i      in   1        begin sweep (level sampled, acted on in IDLE only)
//  abort_i      in   1        stop sweep, return to IDLE
//  p_inc_o      out  PINC_W   registered increment to accumulator p_inc_i
//  phase_rst_o  out  1        one-cycle pulse to accumulator rst_i at sweep start
//  step_o       out  1        pulse on each cycle p_inc_o changes value
//  busy_o       out  1        high in every state except IDLE
//  done_o       out  1        one-cycle pulse on natural SINGLE completion
// BEHAVIOUR
//  Reset: state IDLE; config regs 0; p_inc_o 0; all pulses 0; busy_o 0; cfg_ready_o 1.
//  Config: captured on cfg_valid_i & cfg_ready_o. Ignored while busy (ready low).
//  FSM states: IDLE, LOAD, DWELL, STEP, DONE.
//   - IDLE: start_i with abort_i low -> LOAD.
//   - LOAD (1 cycle): p_inc_o<=start, phase_rst_o=1, step_o=1; load step_dir/step_cur. -> DWELL.
//   - DWELL: holds p_inc_o until it has been stable exactly max(dwell,1) cycles.
//   - STEP: computes next value, updates p_inc_o, pulses step_o, reloads counter.
//  Latency: start_i sampled at edge N -> p_inc_o=start, phase_rst_o=1 after edge N+1.
//  Arithmetic: next = p_inc_o + step_cur, computed PINC_W+1 wide.
//   - Dir up (step>0): carry-out or next>=target -> clamp to target.
//   - Dir down: borrow or next<=target -> clamp to target.
//   - Clamped value still gets its full dwell; endpoint reached only after that dwell.
//  Endpoint reached:
//   - SINGLE: -> DONE (done_o=1, 1 cycle) -> IDLE; p_inc_o holds stop.
//   - REPEAT: p_inc_o<=start, step_o=1, no phase_rst_o; continue.
//   - TRIANGLE: negate step_cur, swap target (stop<->start), continue. Runs until abort.
//  Degenerate cases: step==0 or start==stop -> one dwell at start, then endpoint handling.
//   - REPEAT/TRIANGLE in this case hold start indefinitely (no step_o) until abort.
//  Wrong-sign step (e.g. step>0, stop<start): clamps to stop on first STEP.
//  abort_i:
//   - any non-IDLE state -> IDLE next edge; p_inc_o holds last value.
//   - no done_o on abort. abort_i beats start_i in the same cycle.
//  Mid-operation reset: asynchronous return to reset values; p_inc_o 0 immediately.
// STRUCTURE
//  nco_ctrl_pkg: state enum, MODE_SINGLE/REPEAT/TRIANGLE constants, PINC_W/DWELL_W defaults.
//  Sub-module dwell_cnt: loadable down-counter.
//   - Inputs: load, value (0 mapped to 1). Output: expire pulse.
//  Top holds config regs, FSM and clamp/compare datapath.
// TESTING
//  1. SINGLE, start=100, stop=130, step=10, dwell=3 -> p_inc_o 100,110,120,130, each 3 cycles;
//     done_o once; then IDLE.
//  2. Down clamp, start=100, stop=75, step=-10 -> 100,90,80,75, then done.
//     Boundary: start=0xFFFF_FFF0, step=0x20, stop=0xFFFF_FFFF -> clamps to 0xFFFF_FFFF, no wrap.
//  3. TRIANGLE, start=0, stop=20, step=10, dwell=1 -> 0,10,20,10,0,10,... ; step_o every cycle.
//  4. abort_i in DWELL at 110 -> IDLE next edge, p_inc_o=110, no done_o.
//     Simultaneous start_i+abort_i in IDLE -> stays IDLE.
//  5. cfg_valid_i while busy -> ignored; after IDLE new config used.
//     dwell=0 behaves as 1; step=0 SINGLE -> one cycle at start, then done.
//  6. rst_i asserted mid-sweep without clock edge -> p_inc_o=0, busy_o=0 asynchronously.
//     phase_rst_o exactly 1 pulse per start.

Source files
------------

// File: rtl/nco_ctrl_pkg.sv
// Shared types and constants for the NCO frequency sweep sequencer.
package nco_ctrl_pkg;

  localparam int unsigned PINC_W_DEF  = 32;
  localparam int unsigned DWELL_W_DEF = 16;

  localparam logic [1:0] MODE_SINGLE   = 2'd0;
  localparam logic [1:0] MODE_REPEAT   = 2'd1;
  localparam logic [1:0] MODE_TRIANGLE = 2'd2;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StDwell,
    StStep,
    StDone
  } state_e;

endpackage

// File: rtl/dwell_cnt.sv
// Loadable dwell down-counter; expire_o flags the cycle before the final cycle of a dwell,
// so the sequencer can spend that final cycle in its update state.
module dwell_cnt #(
  parameter int unsigned DWELL_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic [DWELL_W-1:0] value_i,
  output logic               expire_o
);

  logic [DWELL_W-1:0] cnt_d, cnt_q;

  // Loads max(value,1)-1; a loaded zero never expires, which doubles as an indefinite hold.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = (value_i == '0) ? '0 : value_i - DWELL_W'(1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - DWELL_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == DWELL_W'(1));

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Frequency sweep/hop sequencer driving the phase-increment and phase reset of a 4-lane NCO.
// Supports single chirp, repeating sawtooth and triangle sweeps with a programmable dwell.
module nco_sweep_ctrl
  import nco_ctrl_pkg::*;
#(
  parameter int unsigned PINC_W  = PINC_W_DEF,
  parameter int unsigned DWELL_W = DWELL_W_DEF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cfg_valid_i,
  output logic               cfg_ready_o,
  input  logic [PINC_W-1:0]  cfg_start_i,
  input  logic [PINC_W-1:0]  cfg_stop_i,
  input  logic [PINC_W-1:0]  cfg_step_i,
  input  logic [DWELL_W-1:0] cfg_dwell_i,
  input  logic [1:0]         cfg_mode_i,
  input  logic               start_i,
  input  logic               abort_i,
  output logic [PINC_W-1:0]  p_inc_o,
  output logic               phase_rst_o,
  output logic               step_o,
  output logic               busy_o,
  output logic               done_o
);

  state_e state_d, state_q;

  logic [PINC_W-1:0]  cfg_start_d, cfg_start_q;
  logic [PINC_W-1:0]  cfg_stop_d, cfg_stop_q;
  logic [PINC_W-1:0]  cfg_step_d, cfg_step_q;
  logic [DWELL_W-1:0] cfg_dwell_d, cfg_dwell_q;
  logic [1:0]         cfg_mode_d, cfg_mode_q;

  logic [PINC_W-1:0] p_inc_d, p_inc_q;
  logic [PINC_W-1:0] step_cur_d, step_cur_q;
  logic              step_dir_d, step_dir_q;     // 1: counting up
  logic              toward_stop_d, toward_stop_q;
  logic              phase_rst_d, phase_rst_q;
  logic              step_d, step_q;
  logic              done_d, done_q;

  logic               cnt_load;
  logic [DWELL_W-1:0] cnt_value;
  logic               cnt_expire;

  logic              is_repeat, is_triangle, short_dwell, degenerate, at_end, turn;
  logic              dir_use, clamp;
  logic [PINC_W-1:0] step_use, tgt_cur, tgt_use, next_val;
  logic [PINC_W:0]   sum;
  state_e            cont_state;

  // ---------------- datapath ----------------
  always_comb begin
    is_repeat   = (cfg_mode_q == MODE_REPEAT);
    is_triangle = (cfg_mode_q == MODE_TRIANGLE);
    short_dwell = (cfg_dwell_q <= DWELL_W'(1));
    cont_state  = short_dwell ? StStep : StDwell;
    degenerate  = (cfg_start_q == cfg_stop_q) || (step_cur_q == '0);
    tgt_cur     = toward_stop_q ? cfg_stop_q : cfg_start_q;
    at_end      = (p_inc_q == tgt_cur) || (step_cur_q == '0);
    // A triangle turnaround moves off the endpoint in the same update.
    turn        = at_end && is_triangle && !degenerate;
    step_use    = turn ? -step_cur_q : step_cur_q;
    dir_use     = turn ? !step_dir_q : step_dir_q;
    tgt_use     = (toward_stop_q ^ turn) ? cfg_stop_q : cfg_start_q;
    // Sign-extended add: bit PINC_W flags carry-out (up) or borrow (down).
    sum         = {1'b0, p_inc_q} + {step_use[PINC_W-1], step_use};
    clamp       = sum[PINC_W] ||
                  (dir_use ? (sum[PINC_W-1:0] >= tgt_use) : (sum[PINC_W-1:0] <= tgt_use));
    next_val    = clamp ? tgt_use : sum[PINC_W-1:0];
  end

  // ---------------- config capture ----------------
  always_comb begin
    cfg_start_d = cfg_start_q;
    cfg_stop_d  = cfg_stop_q;
    cfg_step_d  = cfg_step_q;
    cfg_dwell_d = cfg_dwell_q;
    cfg_mode_d  = cfg_mode_q;
    if (cfg_valid_i && cfg_ready_o) begin
      cfg_start_d = cfg_start_i;
      cfg_stop_d  = cfg_stop_i;
      cfg_step_d  = cfg_step_i;
      cfg_dwell_d = cfg_dwell_i;
      cfg_mode_d  = cfg_mode_i;
    end
  end

  // ---------------- FSM next state / outputs ----------------
  always_comb begin
    state_d       = state_q;
    p_inc_d       = p_inc_q;
    step_cur_d    = step_cur_q;
    step_dir_d    = step_dir_q;
    toward_stop_d = toward_stop_q;
    phase_rst_d   = 1'b0;
    step_d        = 1'b0;
    done_d        = 1'b0;
    cnt_load      = 1'b0;
    cnt_value     = cfg_dwell_q;

    unique case (state_q)
      StIdle: begin
        if (start_i && !abort_i) state_d = StLoad;
      end
      StLoad: begin
        p_inc_d       = cfg_start_q;
        phase_rst_d   = 1'b1;
        step_d        = 1'b1;
        step_cur_d    = cfg_step_q;
        step_dir_d    = !cfg_step_q[PINC_W-1];
        toward_stop_d = 1'b1;
        cnt_load      = 1'b1;
        state_d       = cont_state;
      end
      StDwell: begin
        if (cnt_expire) state_d = StStep;
      end
      StStep: begin
        if (at_end && !is_repeat && !is_triangle) begin
          done_d  = 1'b1;
          state_d = StDone;
        end else if (at_end && degenerate) begin
          // Nothing to sweep: park on the start value until aborted.
          cnt_load  = 1'b1;
          cnt_value = DWELL_W'(1);
          state_d   = StDwell;
        end else begin
          p_inc_d  = (at_end && is_repeat) ? cfg_start_q : next_val;
          step_d   = 1'b1;
          cnt_load = 1'b1;
          state_d  = cont_state;
          if (turn) begin
            step_cur_d    = step_use;
            step_dir_d    = dir_use;
            toward_stop_d = !toward_stop_q;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (abort_i && (state_q != StIdle)) begin
      state_d     = StIdle;
      p_inc_d     = p_inc_q;
      phase_rst_d = 1'b0;
      step_d      = 1'b0;
      done_d      = 1'b0;
      cnt_load    = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      cfg_start_q   <= '0;
      cfg_stop_q    <= '0;
      cfg_step_q    <= '0;
      cfg_dwell_q   <= '0;
      cfg_mode_q    <= MODE_SINGLE;
      p_inc_q       <= '0;
      step_cur_q    <= '0;
      step_dir_q    <= 1'b1;
      toward_stop_q <= 1'b1;
      phase_rst_q   <= 1'b0;
      step_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cfg_start_q   <= cfg_start_d;
      cfg_stop_q    <= cfg_stop_d;
      cfg_step_q    <= cfg_step_d;
      cfg_dwell_q   <= cfg_dwell_d;
      cfg_mode_q    <= cfg_mode_d;
      p_inc_q       <= p_inc_d;
      step_cur_q    <= step_cur_d;
      step_dir_q    <= step_dir_d;
      toward_stop_q <= toward_stop_d;
      phase_rst_q   <= phase_rst_d;
      step_q        <= step_d;
      done_q        <= done_d;
    end
  end

  dwell_cnt #(
    .DWELL_W (DWELL_W)
  ) u_dwell_cnt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (cnt_load),
    .value_i  (cnt_value),
    .expire_o (cnt_expire)
  );

  assign cfg_ready_o = (state_q == StIdle);
  assign busy_o      = (state_q != StIdle);
  assign p_inc_o     = p_inc_q;
  assign phase_rst_o = phase_rst_q;
  assign step_o      = step_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Directed bench for nco_sweep_ctrl: one task per scenario with hand-computed expectations.
module tb_nco_sweep_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cfg_valid_i;
  logic        cfg_ready_o;
  logic [31:0] cfg_start_i, cfg_stop_i, cfg_step_i;
  logic [15:0] cfg_dwell_i;
  logic [1:0]  cfg_mode_i;
  logic        start_i, abort_i;
  logic [31:0] p_inc_o;
  logic        phase_rst_o, step_o, busy_o, done_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  nco_sweep_ctrl #(
    .PINC_W  (32),
    .DWELL_W (16)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cfg_valid_i (cfg_valid_i),
    .cfg_ready_o (cfg_ready_o),
    .cfg_start_i (cfg_start_i),
    .cfg_stop_i  (cfg_stop_i),
    .cfg_step_i  (cfg_step_i),
    .cfg_dwell_i (cfg_dwell_i),
    .cfg_mode_i  (cfg_mode_i),
    .start_i     (start_i),
    .abort_i     (abort_i),
    .p_inc_o     (p_inc_o),
    .phase_rst_o (phase_rst_o),
    .step_o      (step_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic apply_cfg(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                           input logic [15:0] dw, input logic [1:0] m);
    cfg_start_i = s;
    cfg_stop_i  = e;
    cfg_step_i  = st;
    cfg_dwell_i = dw;
    cfg_mode_i  = m;
    cfg_valid_i = 1'b1;
    tick();
    cfg_valid_i = 1'b0;
  endtask

  task automatic kick();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic do_abort();
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (p_inc_o !== 32'd0) begin bad++; $display("FAIL reset p_inc got=%h exp=0", p_inc_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset busy got=%b exp=0", busy_o); end
    total++; if (cfg_ready_o !== 1'b1) begin bad++; $display("FAIL reset ready got=%b exp=1", cfg_ready_o); end
    total++;
    if ({phase_rst_o, step_o, done_o} !== 3'b000) begin
      bad++; $display("FAIL reset pulses got=%b exp=000", {phase_rst_o, step_o, done_o});
    end
  endtask

  task automatic test_single();
    logic [31:0] exp;
    int n_prst = 0;
    apply_cfg(32'd100, 32'd130, 32'd10, 16'd3, 2'd0);
    kick();
    for (int k = 1; k <= 14; k++) begin
      tick();
      exp = (k <= 12) ? 32'(100 + 10 * ((k - 1) / 3)) : 32'd130;
      n_prst += int'(phase_rst_o);
      total++; if (p_inc_o !== exp) begin bad++; $display("FAIL single p_inc k=%0d got=%0d exp=%0d", k, p_inc_o, exp); end
      total++; if (step_o !== (k <= 12 && (k % 3) == 1)) begin bad++; $display("FAIL single step k=%0d got=%b", k, step_o); end
      total++; if (done_o !== (k == 13)) begin bad++; $display("FAIL single done k=%0d got=%b", k, done_o); end
      total++; if (busy_o !== (k <= 13)) begin bad++; $display("FAIL single busy k=%0d got=%b", k, busy_o); end
      total++; if (phase_rst_o !== (k == 1)) begin bad++; $display("FAIL single phase_rst k=%0d got=%b", k, phase_rst_o); end
    end
    total++; if (n_prst != 1) begin bad++; $display("FAIL single phase_rst count got=%0d exp=1", n_prst); end
  endtask

  task automatic test_down_clamp();
    logic [31:0] dv [4];
    logic [31:0] exp;
    dv = '{32'd100, 32'd90, 32'd80, 32'd75};
    apply_cfg(32'd100, 32'd75, 32'hFFFF_FFF6, 16'd2, 2'd0);
    kick();
    for (int k = 1; k <= 10; k++) begin
      tick();
      exp = (k <= 8) ? dv[(k - 1) / 2] : 32'd75;
      total++; if (p_inc_o !== exp) begin bad++; $display("FAIL down p_inc k=%0d got=%0d exp=%0d", k, p_inc_o, exp); end
      total++; if (done_o !== (k == 9)) begin bad++; $display("FAIL down done k=%0d got=%b", k, done_o); end
    end
    // Top-of-range clamp must not wrap to a small value.
    apply_cfg(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 16'd1, 2'd0);
    kick();
    tick();
    total++; if (p_inc_o !== 32'hFFFF_FFF0) begin bad++; $display("FAIL wrap k1 got=%h exp=fffffff0", p_inc_o); end
    tick();
    total++; if (p_inc_o !== 32'hFFFF_FFFF) begin bad++; $display("FAIL wrap clamp got=%h exp=ffffffff", p_inc_o); end
    total++; if (step_o !== 1'b1) begin bad++; $display("FAIL wrap step got=%b exp=1", step_o); end
    tick();
    total++; if (done_o !== 1'b1 || p_inc_o !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL wrap done got=%b p=%h exp=1 ffffffff", done_o, p_inc_o);
    end
    tick();
  endtask

  task automatic test_triangle();
    logic [31:0] tv [8];
    tv = '{32'd0, 32'd10, 32'd20, 32'd10, 32'd0, 32'd10, 32'd20, 32'd10};
    apply_cfg(32'd0, 32'd20, 32'd10, 16'd1, 2'd2);
    kick();
    for (int k = 1; k <= 8; k++) begin
      tick();
      total++; if (p_inc_o !== tv[k-1]) begin bad++; $display("FAIL tri p_inc k=%0d got=%0d exp=%0d", k, p_inc_o, tv[k-1]); end
      total++; if (step_o !== 1'b1) begin bad++; $display("FAIL tri step k=%0d got=%b exp=1", k, step_o); end
      total++; if (phase_rst_o !== (k == 1)) begin bad++; $display("FAIL tri phase_rst k=%0d got=%b", k, phase_rst_o); end
    end
    do_abort();
    total++; if (busy_o !== 1'b0 || p_inc_o !== 32'd10 || step_o !== 1'b0) begin
      bad++; $display("FAIL tri abort busy=%b p=%0d step=%b exp 0 10 0", busy_o, p_inc_o, step_o);
    end
  endtask

  task automatic test_repeat();
    logic [31:0] rv [5];
    rv = '{32'd0, 32'd10, 32'd20, 32'd0, 32'd10};
    apply_cfg(32'd0, 32'd20, 32'd10, 16'd2, 2'd1);
    kick();
    for (int k = 1; k <= 10; k++) begin
      tick();
      total++; if (p_inc_o !== rv[(k-1)/2]) begin bad++; $display("FAIL rep p_inc k=%0d got=%0d exp=%0d", k, p_inc_o, rv[(k-1)/2]); end
      total++; if (step_o !== ((k % 2) == 1)) begin bad++; $display("FAIL rep step k=%0d got=%b", k, step_o); end
      total++; if (phase_rst_o !== (k == 1)) begin bad++; $display("FAIL rep phase_rst k=%0d got=%b", k, phase_rst_o); end
    end
    do_abort();
    // start==stop: park on start with no further steps.
    apply_cfg(32'd50, 32'd50, 32'd10, 16'd1, 2'd1);
    kick();
    for (int k = 1; k <= 6; k++) begin
      tick();
      total++; if (p_inc_o !== 32'd50) begin bad++; $display("FAIL hold p_inc k=%0d got=%0d exp=50", k, p_inc_o); end
      total++; if (step_o !== (k == 1)) begin bad++; $display("FAIL hold step k=%0d got=%b", k, step_o); end
      total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL hold busy k=%0d got=%b exp=1", k, busy_o); end
    end
    do_abort();
  endtask

  task automatic test_abort();
    apply_cfg(32'd100, 32'd130, 32'd10, 16'd3, 2'd0);
    kick();
    for (int k = 1; k <= 5; k++) tick();
    total++; if (p_inc_o !== 32'd110) begin bad++; $display("FAIL abort pre p_inc got=%0d exp=110", p_inc_o); end
    do_abort();
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL abort busy got=%b exp=0", busy_o); end
    for (int k = 0; k < 4; k++) begin
      total++; if (done_o !== 1'b0 || p_inc_o !== 32'd110) begin
        bad++; $display("FAIL abort hold k=%0d done=%b p=%0d exp 0 110", k, done_o, p_inc_o);
      end
      tick();
    end
    start_i = 1'b1;
    abort_i = 1'b1;
    tick();
    start_i = 1'b0;
    abort_i = 1'b0;
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL start+abort busy got=%b exp=0", busy_o); end
    tick();
    total++; if (busy_o !== 1'b0 || phase_rst_o !== 1'b0) begin
      bad++; $display("FAIL start+abort later busy=%b prst=%b exp 0 0", busy_o, phase_rst_o);
    end
  endtask

  task automatic test_cfg_busy();
    apply_cfg(32'd0, 32'd30, 32'd10, 16'd1, 2'd0);
    kick();
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 1) begin
        total++; if (cfg_ready_o !== 1'b0) begin bad++; $display("FAIL busy ready got=%b exp=0", cfg_ready_o); end
        cfg_start_i = 32'd500;
        cfg_stop_i  = 32'd900;
        cfg_mode_i  = 2'd1;
        cfg_valid_i = 1'b1;
      end else begin
        cfg_valid_i = 1'b0;
      end
      total++; if (p_inc_o !== ((k <= 4) ? 32'(10 * (k - 1)) : 32'd30)) begin
        bad++; $display("FAIL busy p_inc k=%0d got=%0d", k, p_inc_o);
      end
      total++; if (done_o !== (k == 5)) begin bad++; $display("FAIL busy done k=%0d got=%b", k, done_o); end
    end
    // Rerun: the config offered while busy must not have been taken.
    kick();
    tick();
    total++; if (p_inc_o !== 32'd0) begin bad++; $display("FAIL busy ignore got=%0d exp=0", p_inc_o); end
    for (int k = 0; k < 5; k++) tick();
    apply_cfg(32'd5, 32'd7, 32'd1, 16'd0, 2'd0);
    kick();
    for (int k = 1; k <= 4; k++) begin
      tick();
      total++; if (p_inc_o !== ((k <= 3) ? 32'(4 + k) : 32'd7)) begin
        bad++; $display("FAIL dwell0 p_inc k=%0d got=%0d", k, p_inc_o);
      end
      total++; if (done_o !== (k == 4)) begin bad++; $display("FAIL dwell0 done k=%0d got=%b", k, done_o); end
    end
    tick();
    apply_cfg(32'd200, 32'd400, 32'd0, 16'd0, 2'd0);
    kick();
    tick();
    total++; if (p_inc_o !== 32'd200 || done_o !== 1'b0) begin bad++; $display("FAIL step0 k1 p=%0d done=%b", p_inc_o, done_o); end
    tick();
    total++; if (p_inc_o !== 32'd200 || done_o !== 1'b1) begin bad++; $display("FAIL step0 k2 p=%0d done=%b", p_inc_o, done_o); end
    tick();
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL step0 idle busy=%b exp=0", busy_o); end
  endtask

  task automatic test_async_reset();
    apply_cfg(32'd100, 32'd130, 32'd10, 16'd3, 2'd0);
    kick();
    for (int k = 1; k <= 5; k++) tick();
    #3;
    rst_i = 1'b1;
    #1;
    total++; if (p_inc_o !== 32'd0) begin bad++; $display("FAIL arst p_inc got=%0d exp=0", p_inc_o); end
    total++; if (busy_o !== 1'b0 || cfg_ready_o !== 1'b1) begin
      bad++; $display("FAIL arst busy=%b ready=%b exp 0 1", busy_o, cfg_ready_o);
    end
    #2;
    rst_i = 1'b0;
    tick();
    total++; if (busy_o !== 1'b0 || p_inc_o !== 32'd0) begin bad++; $display("FAIL arst after busy=%b p=%0d", busy_o, p_inc_o); end
    // Config was cleared: all-zero SINGLE sweep finishes after one cycle.
    kick();
    tick();
    total++; if (phase_rst_o !== 1'b1 || p_inc_o !== 32'd0) begin
      bad++; $display("FAIL arst cfg0 prst=%b p=%0d exp 1 0", phase_rst_o, p_inc_o);
    end
    tick();
    total++; if (done_o !== 1'b1) begin bad++; $display("FAIL arst cfg0 done got=%b exp=1", done_o); end
    tick();
  endtask

  initial begin
    rst_i       = 1'b1;
    cfg_valid_i = 1'b0;
    cfg_start_i = '0;
    cfg_stop_i  = '0;
    cfg_step_i  = '0;
    cfg_dwell_i = '0;
    cfg_mode_i  = '0;
    start_i     = 1'b0;
    abort_i     = 1'b0;
    tick();
    tick();
    test_reset();
    rst_i = 1'b0;
    tick();
    test_reset();
    test_single();
    test_down_clamp();
    test_triangle();
    test_repeat();
    test_abort();
    test_cfg_busy();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
